// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: ALU opcodes, forwarding selects and flag layout.
package core_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLL = 4'd5,
    SRL = 4'd6,
    SRA = 4'd7,
    MOV = 4'd8,
    CMP = 4'd9
  } aluOp_t;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // flags register is packed {S,Z,C,V}
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // MOV and undefined encodings leave the flag register untouched
  function automatic logic updatesFlags(input logic [3:0] op);
    return (op <= CMP) && (op != MOV);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus S/Z/C/V status for one operation.
module alu
  import core_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              s,
  output logic              z,
  output logic              c,
  output logic              v
);

  logic [SHAMT_W-1:0]      shamt;
  logic [DATA_W:0]         sum;
  logic [DATA_W:0]         diff;
  logic [DATA_W:0]         shlExt;
  logic [DATA_W:0]         shrExt;
  logic signed [DATA_W:0]  sraExt;

  // Shifts run on a one-bit-wider copy so the last bit shifted out lands in the extra bit.
  assign shamt  = b[SHAMT_W-1:0];
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign shlExt = {1'b0, a} << shamt;
  assign shrExt = {a, 1'b0} >> shamt;
  assign sraExt = $signed({a, 1'b0}) >>> shamt;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
        v      = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      SUB, CMP: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
        v      = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      AND: result = a & b;
      OR:  result = a | b;
      XOR: result = a ^ b;
      SLL: begin
        result = shlExt[DATA_W-1:0];
        c      = shlExt[DATA_W];
      end
      SRL: begin
        result = shrExt[DATA_W:1];
        c      = shrExt[0];
      end
      SRA: begin
        result = sraExt[DATA_W:1];
        c      = sraExt[0];
      end
      MOV: result = b;
      default: result = '0;
    endcase
    s = result[DATA_W-1];
    z = (result == '0);
  end

endmodule

// File: rtl/ex_stage.sv
// EX stage: operand forwarding muxes, ALU, SZCV flag register, EX/MEM pipeline registers
// and load-use hazard detection toward ID.
module ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              hold,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [3:0]        alu_op,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        dest,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [DATA_W-1:0] fwd_3_4_data,
  input  logic [DATA_W-1:0] fwd_4_5_data,
  input  logic [2:0]        id_reg1,
  input  logic [2:0]        id_reg2,
  output logic              load_use_stall,
  output logic              valid_3_4,
  output logic              regWrite_3_4,
  output logic              mem_read_3_4,
  output logic              mem_write_3_4,
  output logic [2:0]        dest_3_4,
  output logic [DATA_W-1:0] alu_result_3_4,
  output logic [DATA_W-1:0] store_data_3_4,
  output logic [3:0]        flags
);

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluResult;
  logic              aluS, aluZ, aluC, aluV;

  // 2'b11 is unused by the forwarding unit and falls back to the register file.
  always_comb begin
    case (forwardA)
      FWD_EX_MEM: opA = fwd_3_4_data;
      FWD_MEM_WB: opA = fwd_4_5_data;
      default:    opA = rs_data;
    endcase
    case (forwardB)
      FWD_EX_MEM: fwdB = fwd_3_4_data;
      FWD_MEM_WB: fwdB = fwd_4_5_data;
      default:    fwdB = rt_data;
    endcase
    opB = use_imm ? imm : fwdB;
  end

  alu #(
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_alu (
    .a     (opA),
    .b     (opB),
    .op    (alu_op),
    .result(aluResult),
    .s     (aluS),
    .z     (aluZ),
    .c     (aluC),
    .v     (aluV)
  );

  assign load_use_stall = in_valid & ~flush & mem_read & (dest != 3'd0) &
                          ((dest == id_reg1) | (dest == id_reg2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_3_4      <= 1'b0;
      regWrite_3_4   <= 1'b0;
      mem_read_3_4   <= 1'b0;
      mem_write_3_4  <= 1'b0;
      dest_3_4       <= '0;
      alu_result_3_4 <= '0;
      store_data_3_4 <= '0;
      flags          <= '0;
    end else if (!hold) begin
      if (flush || !in_valid) begin
        // Bubble: everything cleared except the architectural flags.
        valid_3_4      <= 1'b0;
        regWrite_3_4   <= 1'b0;
        mem_read_3_4   <= 1'b0;
        mem_write_3_4  <= 1'b0;
        dest_3_4       <= '0;
        alu_result_3_4 <= '0;
        store_data_3_4 <= '0;
      end else begin
        valid_3_4      <= 1'b1;
        regWrite_3_4   <= reg_write;
        mem_read_3_4   <= mem_read;
        mem_write_3_4  <= mem_write;
        dest_3_4       <= dest;
        alu_result_3_4 <= aluResult;
        store_data_3_4 <= fwdB;
        if (updatesFlags(alu_op)) begin
          flags[FLAG_S] <= aluS;
          flags[FLAG_Z] <= aluZ;
          flags[FLAG_C] <= aluC;
          flags[FLAG_V] <= aluV;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected EX/MEM state, one task per scenario.
module tb_ex_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, hold, flush, use_imm;
  logic        reg_write, mem_read, mem_write;
  logic [15:0] rs_data, rt_data, imm, fwd_3_4_data, fwd_4_5_data;
  logic [3:0]  alu_op;
  logic [2:0]  dest, id_reg1, id_reg2;
  logic [1:0]  forwardA, forwardB;
  logic        load_use_stall, valid_3_4, regWrite_3_4, mem_read_3_4, mem_write_3_4;
  logic [2:0]  dest_3_4;
  logic [15:0] alu_result_3_4, store_data_3_4;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;   // {valid, regWrite, mem_read, mem_write}
    logic [2:0]  dest;
    logic [15:0] res;
    logic [15:0] store;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .hold(hold), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .use_imm(use_imm),
    .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .dest(dest), .forwardA(forwardA), .forwardB(forwardB),
    .fwd_3_4_data(fwd_3_4_data), .fwd_4_5_data(fwd_4_5_data),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .load_use_stall(load_use_stall),
    .valid_3_4(valid_3_4), .regWrite_3_4(regWrite_3_4), .mem_read_3_4(mem_read_3_4),
    .mem_write_3_4(mem_write_3_4), .dest_3_4(dest_3_4), .alu_result_3_4(alu_result_3_4),
    .store_data_3_4(store_data_3_4), .flags(flags)
  );

  task automatic idle();
    in_valid = 0; hold = 0; flush = 0; use_imm = 0;
    reg_write = 0; mem_read = 0; mem_write = 0;
    rs_data = 0; rt_data = 0; imm = 0; fwd_3_4_data = 0; fwd_4_5_data = 0;
    alu_op = 0; dest = 0; id_reg1 = 0; id_reg2 = 0; forwardA = 0; forwardB = 0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] rs, input logic [15:0] rt,
                       input logic [15:0] im, input logic ui, input logic [1:0] fa,
                       input logic [1:0] fb, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] d);
    in_valid = 1; alu_op = op; rs_data = rs; rt_data = rt; imm = im; use_imm = ui;
    forwardA = fa; forwardB = fb; reg_write = rw; mem_read = mr; mem_write = mw; dest = d;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] ctrl, input logic [2:0] d,
                            input logic [15:0] res, input logic [15:0] st, input logic [3:0] fl);
    exp_t e;
    e.name = nm; e.ctrl = ctrl; e.dest = d; e.res = res; e.store = st; e.flags = fl;
    sb.push_back(e);
  endtask

  task automatic expect_last(input string nm);
    expect_out(nm, last.ctrl, last.dest, last.res, last.store, last.flags);
  endtask

  task automatic expect_bubble(input string nm);
    expect_out(nm, 4'b0000, 3'd0, 16'h0, 16'h0, last.flags);
  endtask

  task automatic tick_check();
    exp_t e;
    logic [3:0] ctrl;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got output with no expectation");
      return;
    end
    e = sb.pop_front();
    last = e;
    ctrl = {valid_3_4, regWrite_3_4, mem_read_3_4, mem_write_3_4};
    if (ctrl !== e.ctrl) begin
      errors++; $display("FAIL %s ctrl: got %b expected %b", e.name, ctrl, e.ctrl);
    end
    checks++;
    if (dest_3_4 !== e.dest) begin
      errors++; $display("FAIL %s dest: got %0d expected %0d", e.name, dest_3_4, e.dest);
    end
    checks++;
    if (alu_result_3_4 !== e.res) begin
      errors++; $display("FAIL %s result: got %h expected %h", e.name, alu_result_3_4, e.res);
    end
    checks++;
    if (store_data_3_4 !== e.store) begin
      errors++; $display("FAIL %s store: got %h expected %h", e.name, store_data_3_4, e.store);
    end
    checks++;
    if (flags !== e.flags) begin
      errors++; $display("FAIL %s flags: got %b expected %b", e.name, flags, e.flags);
    end
    $display("txn %-12s res=%h store=%h flags=%b ctrl=%b dest=%0d",
             e.name, alu_result_3_4, store_data_3_4, flags, ctrl, dest_3_4);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({valid_3_4, regWrite_3_4, mem_read_3_4, mem_write_3_4, dest_3_4,
         alu_result_3_4, store_data_3_4, flags} !== '0) begin
      errors++;
      $display("FAIL %s: got res=%h store=%h flags=%b valid=%b expected all zero",
               nm, alu_result_3_4, store_data_3_4, flags, valid_3_4);
    end
    $display("txn %-12s res=%h flags=%b valid=%b", nm, alu_result_3_4, flags, valid_3_4);
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;
    last.flags = 4'b0000;
    drive(ADD, 16'h0001, 16'h0002, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'd4);
    expect_out("pre_rst_add", 4'b1100, 3'd4, 16'h0003, 16'h0002, 4'b0000);
    tick_check();
    #2 rst = 1;
    #1;
    check_zero("async_rst");
    rst = 0;
    idle();
    last.flags = 4'b0000;
  endtask

  task automatic test_add_sub();
    drive(ADD, 16'h7FFF, 16'h0001, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'd1);
    expect_out("add_ovf", 4'b1100, 3'd1, 16'h8000, 16'h0001, 4'b1001);
    tick_check();
    drive(SUB, 16'h0000, 16'h0001, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'd2);
    expect_out("sub_borrow", 4'b1100, 3'd2, 16'hFFFF, 16'h0001, 4'b1010);
    tick_check();
  endtask

  task automatic test_forward();
    fwd_3_4_data = 16'h2222;
    fwd_4_5_data = 16'h3333;
    drive(ADD, 16'h1111, 16'h0000, 16'h0, 0, FWD_EX_MEM, FWD_REG, 1, 0, 0, 3'd3);
    expect_out("fwd_a_exmem", 4'b1100, 3'd3, 16'h2222, 16'h0000, 4'b0000);
    tick_check();
    drive(ADD, 16'h1111, 16'h0000, 16'h0, 0, FWD_MEM_WB, FWD_REG, 1, 0, 0, 3'd3);
    expect_out("fwd_a_memwb", 4'b1100, 3'd3, 16'h3333, 16'h0000, 4'b0000);
    tick_check();
    drive(ADD, 16'h1111, 16'h0000, 16'h0, 0, 2'b11, FWD_REG, 1, 0, 0, 3'd3);
    expect_out("fwd_a_11", 4'b1100, 3'd3, 16'h1111, 16'h0000, 4'b0000);
    tick_check();
  endtask

  task automatic test_load_use();
    // Registers held so the combinational probing cannot disturb the scoreboard.
    hold = 1;
    in_valid = 1; mem_read = 1; dest = 3'd3; id_reg1 = 3'd1; id_reg2 = 3'd3; flush = 0;
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      errors++; $display("FAIL load_use_hit: got %b expected 1", load_use_stall);
    end
    $display("txn %-12s stall=%b", "lu_hit", load_use_stall);
    dest = 3'd0; id_reg1 = 3'd0; id_reg2 = 3'd5;
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_r0: got %b expected 0", load_use_stall);
    end
    $display("txn %-12s stall=%b", "lu_r0", load_use_stall);
    dest = 3'd3; id_reg2 = 3'd3; flush = 1;
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_flush: got %b expected 0", load_use_stall);
    end
    $display("txn %-12s stall=%b", "lu_flush", load_use_stall);
    flush = 0; mem_read = 0;
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL load_use_noload: got %b expected 0", load_use_stall);
    end
    $display("txn %-12s stall=%b", "lu_noload", load_use_stall);
    idle();
  endtask

  task automatic test_hold_flush();
    drive(XOR, 16'hF0F0, 16'h0FF0, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'd5);
    expect_out("xor", 4'b1100, 3'd5, 16'hFF00, 16'h0FF0, 4'b1000);
    tick_check();
    drive(SUB, 16'h0005, 16'h0003, 16'h0, 0, FWD_REG, FWD_REG, 1, 1, 0, 3'd6);
    hold = 1;
    for (int i = 0; i < 2; i++) begin
      expect_last("hold");
      tick_check();
    end
    flush = 1;
    expect_last("hold_flush");
    tick_check();
    hold = 0;
    expect_bubble("flush");
    tick_check();
    flush = 0; in_valid = 0;
    expect_bubble("invalid");
    tick_check();
  endtask

  task automatic test_shift();
    drive(SRA, 16'h8001, 16'h0, 16'h0001, 1, FWD_REG, FWD_REG, 1, 0, 0, 3'd1);
    expect_out("sra", 4'b1100, 3'd1, 16'hC000, 16'h0000, 4'b1010);
    tick_check();
    drive(SLL, 16'h1234, 16'h0, 16'h0000, 1, FWD_REG, FWD_REG, 1, 0, 0, 3'd2);
    expect_out("sll0", 4'b1100, 3'd2, 16'h1234, 16'h0000, 4'b0000);
    tick_check();
    drive(SRL, 16'h0003, 16'h0002, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'd2);
    expect_out("srl", 4'b1100, 3'd2, 16'h0000, 16'h0002, 4'b0110);
    tick_check();
    drive(MOV, 16'hAAAA, 16'h0, 16'h0000, 1, FWD_REG, FWD_REG, 1, 0, 0, 3'd7);
    expect_out("mov", 4'b1100, 3'd7, 16'h0000, 16'h0000, 4'b0110);
    tick_check();
    drive(4'hF, 16'h1234, 16'h5678, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'd7);
    expect_out("undef", 4'b1100, 3'd7, 16'h0000, 16'h5678, 4'b0110);
    tick_check();
    drive(CMP, 16'h0005, 16'h0005, 16'h0, 0, FWD_REG, FWD_REG, 0, 0, 0, 3'd0);
    expect_out("cmp", 4'b1000, 3'd0, 16'h0000, 16'h0005, 4'b0100);
    tick_check();
    fwd_3_4_data = 16'hBEEF;
    drive(ADD, 16'h0100, 16'h1111, 16'h0005, 1, FWD_REG, FWD_EX_MEM, 0, 0, 1, 3'd0);
    expect_out("store_fwd", 4'b1001, 3'd0, 16'h0105, 16'hBEEF, 4'b0000);
    tick_check();
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, r;
    int unsigned usum;
    int ssum;
    logic [3:0] fl;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      usum = int'(a) + int'(b);
      ssum = int'($signed(a)) + int'($signed(b));
      r = usum[15:0];
      fl = {r[15], r == 16'h0, usum > 32'd65535, (ssum > 32767) || (ssum < -32768)};
      drive(ADD, a, b, 16'h0, 0, FWD_REG, FWD_REG, 1, 0, 0, 3'(i));
      expect_out("b2b_add", 4'b1100, 3'(i), r, b, fl);
      tick_check();
    end
    idle();
    expect_bubble("drain");
    tick_check();
  endtask

  initial begin
    idle();
    test_reset();
    test_add_sub();
    test_forward();
    test_load_use();
    test_hold_flush();
    test_shift();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
